// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code view and a wrap pulse.
// Optional macro GRAY_CHK_EN adds a sticky single-bit-change checker on o_gray_err.
module bin_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_bin,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
`ifdef GRAY_CHK_EN
  output logic             o_gray_err,
`endif
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] gray_enc(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] w_bin_next;
  logic             w_tc_next;

  // Next binary value and wrap flag: load beats count, count beats hold.
  always_comb begin
    w_bin_next = o_bin;
    w_tc_next  = 1'b0;
    if (i_load) begin
      w_bin_next = i_load_bin;
      w_tc_next  = 1'b0;
    end else if (i_en) begin
      if (i_up_dn) begin
        w_bin_next = o_bin + ONE;
        w_tc_next  = (o_bin == ALL_ONES);
      end else begin
        w_bin_next = o_bin - ONE;
        w_tc_next  = (o_bin == ALL_ZERO);
      end
    end else begin
      w_bin_next = o_bin;
      w_tc_next  = 1'b0;
    end
  end

  // Gray is encoded from the next binary value so both outputs move on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bin  <= ALL_ZERO;
      o_gray <= ALL_ZERO;
      o_tc   <= 1'b0;
    end else begin
      o_bin  <= w_bin_next;
      o_gray <= gray_enc(w_bin_next);
      o_tc   <= w_tc_next;
    end
  end

`ifdef GRAY_CHK_EN
  function automatic logic single_bit(input logic [WIDTH-1:0] v);
    return (v != ALL_ZERO) && ((v & (v - ONE)) == ALL_ZERO);
  endfunction

  logic [WIDTH-1:0] r_gray_prev;
  logic             w_step;
  logic             w_bad_step;

  // A counting step is an enabled edge without a load; only those are checked.
  always_comb begin
    w_step     = 1'b0;
    w_bad_step = 1'b0;
    if (i_en && !i_load) begin
      w_step     = 1'b1;
      w_bad_step = !single_bit(gray_enc(w_bin_next) ^ r_gray_prev);
    end else begin
      w_step     = 1'b0;
      w_bad_step = 1'b0;
    end
  end

  // Shadow of the last issued code plus the sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gray_prev <= ALL_ZERO;
      o_gray_err  <= 1'b0;
    end else begin
      r_gray_prev <= gray_enc(w_bin_next);
      o_gray_err  <= o_gray_err | (w_step & w_bad_step);
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Scoreboard bench for bin_to_gray_counter (WIDTH = 4): directed plan plus random stimulus.
module tb_bin_to_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = 4'd0;
  logic [W-1:0] o_bin;
  logic [W-1:0] o_gray;
  logic         o_tc;
`ifdef GRAY_CHK_EN
  logic         o_gray_err;
`endif

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_bin (load_bin),
    .o_bin      (o_bin),
    .o_gray     (o_gray),
`ifdef GRAY_CHK_EN
    .o_gray_err (o_gray_err),
`endif
    .o_tc       (o_tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int gray;
    int tc;
    int err;
    bit step;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   m_bin = 0;
  int   m_err = 0;
  int   prev_gray = 0;
  bit   corrupt = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model and queue the expectation.
  task automatic step(input bit r, input bit l, input bit e, input bit u, input int lb);
    exp_t x;
    int   nb;
    bit   stp;
    rst = r; load = l; en = e; up_dn = u; load_bin = lb[W-1:0];
    @(posedge clk);
    x.tc = 0;
    stp  = 1'b0;
    if (r) begin
      m_bin = 0; m_err = 0;
    end else if (l) begin
      m_bin = lb % 16;
    end else if (e) begin
      nb   = m_bin + (u ? 1 : -1);
      x.tc = (nb < 0 || nb > 15) ? 1 : 0;
      m_bin = (nb + 16) % 16;
      stp  = 1'b1;
      if (corrupt) m_err = 1;
    end
    x.bin  = m_bin;
    x.gray = m_bin ^ (m_bin / 2);
    x.err  = m_err;
    x.step = stp;
    sb_q.push_back(x);
    #1;
  endtask

  // Monitor: every cycle with a pending expectation is compared half a period after the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e_mon = sb_q.pop_front();
      chk("bin", int'(o_bin), e_mon.bin);
      chk("gray", int'(o_gray), e_mon.gray);
      chk("tc", int'(o_tc), e_mon.tc);
`ifdef GRAY_CHK_EN
      chk("gray_err", int'(o_gray_err), e_mon.err);
`endif
      if (e_mon.step) chk("gray_one_bit", $countones(int'(o_gray) ^ prev_gray), 1);
      prev_gray = int'(o_gray);
    end
  end

  initial begin
    #1;
    // 1: reset wins over load and en
    step(1'b1, 1'b1, 1'b1, 1'b1, 10);
    step(1'b1, 1'b1, 1'b1, 1'b1, 10);
    // 2: full up-count with wrap
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // 3: down wrap and next step
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // 4: load with en, then count up
    step(1'b0, 1'b1, 1'b1, 1'b0, 10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // 5: hold at 0110, then reset mid-count
    step(1'b0, 1'b1, 1'b0, 1'b1, 6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    // direction change right at a wrap boundary
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // 6 (checker legal traffic): 32 up, 32 down, load 0101
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(9) == 0),
           ($urandom_range(3) != 0), $urandom_range(1), $urandom_range(15));
    end
`ifdef GRAY_CHK_EN
    // corrupted shadow code makes the next step look like a multi-bit change
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    force dut.r_gray_prev = 4'b1111;
    corrupt = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    release dut.r_gray_prev;
    corrupt = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_counter.md
Name: bin_to_gray_counter

Overview:
- Synchronous up/down counter that keeps its state in binary and presents both the binary value and its Gray-code encoding as registered outputs.
- It is the encode side of the 4-bit Gray-to-binary decode path. It produces Gray sequences for pointers and position codes, where only one bit may change per step.
- A binary value can be loaded and is encoded to Gray on the same edge.

Parameters:
- WIDTH, 4, counter and code width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  load request; takes priority over en.
- load_bin  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- tc  output  1  terminal-count pulse: one cycle, set on the edge where the counter wraps.

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: bin = 0, gray = 0, tc = 0. With the option below compiled in, gray_err = 0 as well.
- Priority per rising edge: rst > load > en > hold.
- Encoding rule: gray = b XOR (b >> 1), where b is the next binary value.
  - Computed from the next value, not the current register, so bin and gray always update on the same edge.
  - gray always equals the encoding of bin; there is never a cycle of skew between them.
- Latency: one cycle. Inputs sampled at edge N are visible on the outputs after edge N.
- load = 1:
  - bin <= load_bin; gray <= encoding of load_bin; tc <= 0.
  - en and up_dn are ignored that cycle.
- en = 1, load = 0:
  - bin <= bin + 1 (up_dn = 1) or bin - 1 (up_dn = 0), modulo 2^WIDTH; gray is updated per the encoding rule.
- Wrap:
  - Up from all-ones to 0, or down from 0 to all-ones, sets tc <= 1 for exactly that one cycle.
  - Any other step clears tc.
- en = 0, load = 0: bin and gray hold; tc <= 0.
- Direction change: takes effect on the next enabled edge. No dead cycle; tc fires only on a real wrap.
- Single-bit property: every en step changes exactly one bit of gray. A load may change any number of bits.
- Reset mid-count: forces all outputs to their reset values on that edge, regardless of load or en.
- No combinational path from any input to any output.

Optional Feature:
- Macro: GRAY_CHK_EN.
- Defined:
  - Adds output gray_err (1 bit) and an internal register holding the previous gray.
  - On every en step (not load, not reset), if popcount(gray_new XOR gray_prev) != 1, gray_err is set.
  - gray_err is sticky and cleared only by rst.
  - The first step after a load compares against the loaded code.
- Not defined: the gray_err port and the checker logic are absent; all other behaviour is identical.

Test Plan (WIDTH = 4):
1. Reset: rst = 1 for 2 cycles with en = 1, load = 1, load_bin = 1010 -> bin = 0000, gray = 0000, tc = 0.
2. Up-count from 0, en = 1, up_dn = 1, 16 edges:
   - gray = 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
   - tc = 1 only on the final edge (bin 1111 -> 0000).
3. Down wrap: from 0000, en = 1, up_dn = 0 -> bin = 1111, gray = 1000, tc = 1. Next down step: bin = 1110, gray = 1001, tc = 0.
4. Load: load = 1, load_bin = 1010 with en = 1 -> bin = 1010, gray = 1111, tc = 0. Next edge, up count -> bin = 1011, gray = 1110.
5. Hold and reset mid-count:
   - At bin = 0110 (gray 0101), en = 0 for 3 cycles -> outputs unchanged, tc = 0.
   - Then rst = 1 with en = 1 -> bin = 0000, gray = 0000.
6. GRAY_CHK_EN defined:
   - 32 up steps, 32 down steps, then load 0101 -> gray_err stays 0.
   - Force a corrupted gray_prev via a bench hook -> gray_err = 1 and stays 1 until rst.
